// File: rtl/ym_lib_pkg.sv
// Shared helpers and encodings for the ym counter cells.
// Imported by the single-slot step logic and the ring bank.
package ym_lib_pkg;

  // Direction encoding of the dec input.
  localparam logic YM_CNT_INC = 1'b0;
  localparam logic YM_CNT_DEC = 1'b1;

  // clog2 with a floor of 1, so a one-entry index still has a real bit.
  function automatic int ym_clog2_min1(input int n);
    int w;
    w = $clog2(n);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/ym_cnt_step.sv
// Combinational update of one counter slot: base select, +/-1, carry/borrow,
// clear and optional saturation. Shared by ring banks and single-slot counters.
module ym_cnt_step
  import ym_lib_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter bit SATURATE   = 1'b0
) (
  input  logic [DATA_WIDTH-1:0] cur,
  input  logic                  c_in,
  input  logic                  dec,
  input  logic                  load,
  input  logic [DATA_WIDTH-1:0] load_val,
  input  logic                  clr,
  output logic                  c_out,
  output logic [DATA_WIDTH-1:0] next
);

  logic [DATA_WIDTH-1:0] base;
  logic [DATA_WIDTH:0]   raw;

  // NOTE: combinational logic uses blocking '=' and gives every output a
  // default first, so no path leaves a value held and no latch is inferred.
  always_comb begin
    base = load ? load_val : cur;
    raw  = {1'b0, base};
    case (dec)
      YM_CNT_INC: raw = {1'b0, base} + {{DATA_WIDTH{1'b0}}, c_in};
      YM_CNT_DEC: raw = {1'b0, base} - {{DATA_WIDTH{1'b0}}, c_in};
      default:    raw = {1'b0, base};
    endcase

    // The extra top bit is set exactly when all-ones+1 or 0-1 occurred.
    c_out = raw[DATA_WIDTH];

    if (clr)
      next = '0;
    else if (SATURATE && c_out)
      next = base;
    else
      next = raw[DATA_WIDTH-1:0];
  end

endmodule

// File: rtl/ym_cnt_ring.sv
// Time-multiplexed bank of CHANNELS counters held in one rotating shift ring.
// ring[0] is the head; its updated value re-enters at the tail on each advance.
module ym_cnt_ring
  import ym_lib_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int CHANNELS   = 6,
  parameter bit SATURATE   = 1'b0,
  localparam int SLOT_W    = ym_clog2_min1(CHANNELS)
) (
  input  logic                  MCLK,
  input  logic                  reset,
  input  logic                  en,
  input  logic                  sync,
  input  logic                  c_in,
  input  logic                  dec,
  input  logic                  load,
  input  logic [DATA_WIDTH-1:0] load_val,
  input  logic                  clr,
  output logic [DATA_WIDTH-1:0] val,
  output logic [SLOT_W-1:0]     slot,
  output logic                  last,
  output logic                  c_out
);

  logic [DATA_WIDTH-1:0] ring [CHANNELS];
  logic [DATA_WIDTH-1:0] next;

  ym_cnt_step #(
    .DATA_WIDTH (DATA_WIDTH),
    .SATURATE   (SATURATE)
  ) u_step (
    .cur      (ring[0]),
    .c_in     (c_in),
    .dec      (dec),
    .load     (load),
    .load_val (load_val),
    .clr      (clr),
    .c_out    (c_out),
    .next     (next)
  );

  assign val  = ring[0];
  assign last = (slot == SLOT_W'(CHANNELS - 1));

  // NOTE: the ring is a handful of flops, not a RAM, so every entry is reset;
  // this keeps X out of val/c_out from the first cycle after reset.
  always_ff @(posedge MCLK or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < CHANNELS; i++)
        ring[i] <= '0;
    end else if (en) begin
      for (int i = 0; i < CHANNELS - 1; i++)
        ring[i] <= ring[i + 1];
      ring[CHANNELS - 1] <= next;
    end
  end

  // Slot label only; sync relabels the incoming head without touching data.
  always_ff @(posedge MCLK or posedge reset) begin
    if (reset)
      slot <= '0;
    else if (en)
      slot <= (sync || last) ? '0 : slot + SLOT_W'(1);
  end

endmodule

// File: tb/tb_ym_cnt_ring.sv
// Directed bench: wrap and saturate builds (W=4, CHANNELS=3) plus a CHANNELS=1
// build, all sharing one stimulus stream with hand-computed expectations.
module tb_ym_cnt_ring;

  logic       MCLK = 1'b0;
  logic       reset;
  logic       en, sync, c_in, dec, load, clr;
  logic [3:0] load_val;

  logic [3:0] w_val, s_val, o_val;
  logic [1:0] w_slot, s_slot;
  logic [0:0] o_slot;
  logic       w_last, s_last, o_last;
  logic       w_c_out, s_c_out, o_c_out;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 MCLK = ~MCLK;

  ym_cnt_ring #(.DATA_WIDTH(4), .CHANNELS(3), .SATURATE(1'b0)) u_wrap (
    .MCLK(MCLK), .reset(reset), .en(en), .sync(sync), .c_in(c_in), .dec(dec),
    .load(load), .load_val(load_val), .clr(clr),
    .val(w_val), .slot(w_slot), .last(w_last), .c_out(w_c_out)
  );

  ym_cnt_ring #(.DATA_WIDTH(4), .CHANNELS(3), .SATURATE(1'b1)) u_sat (
    .MCLK(MCLK), .reset(reset), .en(en), .sync(sync), .c_in(c_in), .dec(dec),
    .load(load), .load_val(load_val), .clr(clr),
    .val(s_val), .slot(s_slot), .last(s_last), .c_out(s_c_out)
  );

  ym_cnt_ring #(.DATA_WIDTH(4), .CHANNELS(1), .SATURATE(1'b0)) u_one (
    .MCLK(MCLK), .reset(reset), .en(en), .sync(sync), .c_in(c_in), .dec(dec),
    .load(load), .load_val(load_val), .clr(clr),
    .val(o_val), .slot(o_slot), .last(o_last), .c_out(o_c_out)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic idle_inputs();
    en = 1'b0; sync = 1'b0; c_in = 1'b0; dec = 1'b0;
    load = 1'b0; clr = 1'b0; load_val = 4'h0;
  endtask

  // One advance with the currently driven controls, then return to idle.
  task automatic tick();
    en = 1'b1;
    @(posedge MCLK);
    #1;
    idle_inputs();
    #1;
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int exp_val [6]  = '{0, 0, 0, 1, 1, 1};
    int exp_slot [6] = '{0, 1, 2, 0, 1, 2};

    idle_inputs();
    reset = 1'b1;
    c_in  = 1'b1;
    dec   = 1'b1;
    #2;
    check("rst_val", w_val, 0);
    check("rst_slot", w_slot, 0);
    check("rst_last", w_last, 0);
    check("rst_c_out", w_c_out, 1);
    check("rst_one_last", o_last, 1);
    check("rst_one_c_out", o_c_out, 1);
    idle_inputs();
    @(negedge MCLK);
    reset = 1'b0;

    // Count up through two rotations.
    for (int i = 0; i < 6; i++) begin
      c_in = 1'b1;
      #1;
      check($sformatf("up_val%0d", i), w_val, exp_val[i]);
      check($sformatf("up_slot%0d", i), w_slot, exp_slot[i]);
      check($sformatf("up_last%0d", i), w_last, (i % 3 == 2) ? 1 : 0);
      tick();
    end
    check("one_val6", o_val, 6);
    check("one_slot", o_slot, 0);
    check("one_last", o_last, 1);

    // Ring now [2,2,2], head slot 0. Load F into slot 1.
    tick();
    load = 1'b1; load_val = 4'hF;
    #1;
    check("load_c_out", w_c_out, 0);
    tick();
    tick();
    tick();
    check("f_val", w_val, 4'hF);
    check("f_slot", w_slot, 1);
    c_in = 1'b1;
    #1;
    check("ovf_c_out_w", w_c_out, 1);
    check("ovf_c_out_s", s_c_out, 1);
    tick();
    tick();
    tick();
    check("ovf_back_w", w_val, 4'h0);
    check("ovf_back_s", s_val, 4'hF);

    // Clear slots 1 and 0 to set up the borrow case on slot 0.
    clr = 1'b1;
    tick();
    tick();
    clr = 1'b1;
    tick();
    tick();
    tick();
    check("zero_slot", w_slot, 0);
    check("zero_val_w", w_val, 0);
    check("zero_val_s", s_val, 0);
    c_in = 1'b1; dec = 1'b1;
    #1;
    check("bor_c_out_w", w_c_out, 1);
    check("bor_c_out_s", s_c_out, 1);
    tick();
    tick();
    tick();
    check("bor_back_w", w_val, 4'hF);
    check("bor_back_s", s_val, 4'h0);

    // Contents: slot0=F(wrap), slot1=0, slot2=2. Relabel at slot 1.
    tick();
    check("pre_sync_slot", w_slot, 1);
    sync = 1'b1;
    tick();
    check("sync_slot", w_slot, 0);
    check("sync_last", w_last, 0);
    check("sync_val", w_val, 2);
    tick();
    check("sync_val1", w_val, 4'hF);
    check("sync_slot1", w_slot, 1);
    tick();
    check("sync_val2", w_val, 0);
    check("sync_last2", w_last, 1);

    // sync without en changes nothing.
    sync = 1'b1;
    @(posedge MCLK);
    #1;
    check("hold_slot", w_slot, 2);
    check("hold_val", w_val, 0);
    idle_inputs();

    // Head 0: load 5 and count -> 6.
    load = 1'b1; load_val = 4'h5; c_in = 1'b1;
    #1;
    check("ldc_c_out", w_c_out, 0);
    tick();
    // Head 2: clr beats load and count.
    clr = 1'b1; load = 1'b1; load_val = 4'h5; c_in = 1'b1;
    #1;
    check("clr_all_c_out", w_c_out, 0);
    tick();
    // Head F: carry still reported while clearing.
    check("clr_f_val", w_val, 4'hF);
    clr = 1'b1; c_in = 1'b1;
    #1;
    check("clr_c_out", w_c_out, 1);
    tick();
    check("ldc_back_w", w_val, 6);
    check("ldc_back_s", s_val, 6);
    tick();
    check("clr_back_w", w_val, 0);
    check("clr_back_s", s_val, 0);
    tick();
    check("clr_f_back", w_val, 0);
    tick();
    check("pre_rst_val", w_val, 6);

    // Asynchronous reset between edges.
    #2;
    reset = 1'b1;
    #1;
    check("arst_val", w_val, 0);
    check("arst_slot", w_slot, 0);
    check("arst_one_val", o_val, 0);
    check("arst_one_last", o_last, 1);
    #1;
    reset = 1'b0;
    c_in = 1'b1;
    tick();
    check("post_rst_slot", w_slot, 1);
    check("post_rst_val", w_val, 0);
    tick();
    tick();
    check("post_rst_val0", w_val, 1);
    check("post_rst_one_val", o_val, 1);
    check("post_rst_one_slot", o_slot, 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
